multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter TIMEOUT, default 15, range 1..255: consecutive FETCH cycles without MemReady before FAULT.
REQ-002 Parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset; ports:
REQ-004 Clk  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 Opcode  in  4  instruction opcode from IR, valid in EXECUTE.
REQ-007 Z  in  1  accumulator-zero flag; C  in  1  carry flag.
REQ-008 MemReady  in  1  instruction memory has data for IR.
REQ-009 Resume  in  1  leave HALT.
REQ-010 LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc  out  1 each  datapath strobes/selects.
REQ-011 SelAcc  out  2  accumulator source: 00 ALU, 01 Reg, 10 Imm.
REQ-012 SelALU  out  4  ALU operation.
REQ-013 MemReq  out  1  fetch request; Halted  out  1; Fault  out  1; IllegalOp  out  1.
REQ-014 InstrCount  out  CNT_W  retired-instruction count.

Function
REQ-015 States SHALL be FETCH, EXECUTE, HALT, FAULT; outputs combinational from state, Opcode, Z, C; all strobes 0 unless stated.
REQ-016 FETCH: MemReq=1; MemReady=1 -> LoadIR=1 same cycle, next EXECUTE; minimum instruction time 2 cycles.
REQ-017 Wait counter SHALL clear on FETCH entry and count FETCH cycles with MemReady=0; at TIMEOUT consecutive such cycles, next FAULT.
REQ-018 MemReady=1 on the TIMEOUT-th wait cycle SHALL take priority over FAULT.
REQ-019 EXECUTE lasts one cycle; next FETCH, except HALT opcode -> HALT state.
REQ-020 ADD 0001, SUB 0010, NOR 0011, SHFL 1011, SHFR 1100: LoadAcc=1, SelAcc=00, SelALU=Opcode, IncPC=1.
REQ-021 SelALU SHALL be 0000 for every non-ALU opcode and every non-EXECUTE state.
REQ-022 REG_TO_ACC 0100: LoadAcc=1, SelAcc=01, IncPC=1; IMM_TO_ACC 1101: LoadAcc=1, SelAcc=10, IncPC=1.
REQ-023 ACC_TO_REG 0101: LoadReg=1, IncPC=1.
REQ-024 JMPZ_REG 0110 / JMPZ_IMM 0111: Z=1 -> LoadPC=1, SelPC=0 (Reg) / 1 (Imm); Z=0 -> IncPC=1.
REQ-025 JMPNZ_REG 1000 / JMPNZ_IMM 1010: Z=0 -> LoadPC=1, SelPC=0 / 1; Z=1 -> IncPC=1.
REQ-026 JMPC_IMM 1001 (new): C=1 -> LoadPC=1, SelPC=1; C=0 -> IncPC=1.
REQ-027 NOP 0000: IncPC=1 only.
REQ-028 Opcode 1110: IncPC=1 and IllegalOp=1 for that cycle; otherwise treated as NOP.
REQ-029 HALT 1111 in EXECUTE: no strobes; HALT state: Halted=1, PC held; Resume=1 -> IncPC=1 same cycle, next FETCH.
REQ-030 LoadPC and IncPC SHALL never be 1 in the same cycle.
REQ-031 FAULT: Fault=1, all other outputs 0 except InstrCount; exit only by reset.
REQ-032 InstrCount SHALL increment by 1 on every EXECUTE cycle (all opcodes incl. HALT, 1110), saturating at 2^CNT_W-1.
REQ-033 Opcode, Z, C SHALL be ignored outside EXECUTE; Resume ignored outside HALT; MemReady ignored outside FETCH.

Reset
REQ-034 reset=1 SHALL immediately force state FETCH, wait counter 0, InstrCount 0, all outputs 0 (MemReq included) while asserted, from any state.
REQ-035 First cycle after reset deassertion: FETCH with MemReq=1.

Verification
REQ-036 Reset 2 cycles, MemReady=1, Opcode=0001 for 10 cycles -> alternating FETCH/EXECUTE; LoadAcc=1, SelALU=0001, IncPC=1 each EXECUTE; InstrCount=5.
REQ-037 Z=1 JMPZ_IMM -> LoadPC=1, SelPC=1; Z=0 same opcode -> IncPC=1, LoadPC=0; Z=1 JMPNZ_REG -> IncPC=1; C=1 opcode 1001 -> LoadPC=1, SelPC=1.
REQ-038 MemReady=0 for 14 cycles then 1 (TIMEOUT=15) -> LoadIR on cycle 15, no Fault; MemReady=0 for 15 cycles -> Fault=1 held until reset.
REQ-039 Opcode=1111, Resume=0 for 5 cycles -> Halted=1, no strobes, InstrCount +1 only; Resume=1 -> IncPC=1, next cycle MemReq=1.
REQ-040 Opcode=1110 -> IllegalOp=1 and IncPC=1 for one cycle; reset asserted mid-HALT -> all outputs 0 immediately, InstrCount=0.
REQ-041 CNT_W=3, 10 EXECUTE cycles -> InstrCount saturates at 7.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle instruction-sequencing controller: FETCH/EXECUTE/HALT/FAULT FSM driving
// datapath strobes combinationally from state and inputs, with fetch timeout and retired count.
module multicycle_controller #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic [3:0]       Opcode,
  input  logic             Z,
  input  logic             C,
  input  logic             MemReady,
  input  logic             Resume,
  output logic             LoadIR,
  output logic             IncPC,
  output logic             SelPC,
  output logic             LoadPC,
  output logic             LoadReg,
  output logic             LoadAcc,
  output logic [1:0]       SelAcc,
  output logic [3:0]       SelALU,
  output logic             MemReq,
  output logic             Halted,
  output logic             Fault,
  output logic             IllegalOp,
  output logic [CNT_W-1:0] InstrCount
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_EXECUTE = 2'd1,
    S_HALT    = 2'd2,
    S_FAULT   = 2'd3
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_NOR   = 4'b0011;
  localparam logic [3:0] OP_R2A   = 4'b0100;
  localparam logic [3:0] OP_A2R   = 4'b0101;
  localparam logic [3:0] OP_JZR   = 4'b0110;
  localparam logic [3:0] OP_JZI   = 4'b0111;
  localparam logic [3:0] OP_JNZR  = 4'b1000;
  localparam logic [3:0] OP_JCI   = 4'b1001;
  localparam logic [3:0] OP_JNZI  = 4'b1010;
  localparam logic [3:0] OP_SHFL  = 4'b1011;
  localparam logic [3:0] OP_SHFR  = 4'b1100;
  localparam logic [3:0] OP_I2A   = 4'b1101;
  localparam logic [3:0] OP_ILL   = 4'b1110;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  // Last wait count before the fetch is declared dead.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_FETCH: begin
        if (MemReady) begin
          state_d = S_EXECUTE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_EXECUTE: begin
        wait_d  = '0;
        state_d = (Opcode == OP_HALT) ? S_HALT : S_FETCH;
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      end
      S_HALT: begin
        if (Resume) begin
          state_d = S_FETCH;
          wait_d  = '0;
        end
      end
      default: state_d = S_FAULT;
    endcase
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end

  assign InstrCount = cnt_q;

  // Reset gates every strobe directly so nothing leaks out while it is held.
  always_comb begin
    LoadIR    = 1'b0;
    IncPC     = 1'b0;
    SelPC     = 1'b0;
    LoadPC    = 1'b0;
    LoadReg   = 1'b0;
    LoadAcc   = 1'b0;
    SelAcc    = 2'b00;
    SelALU    = 4'b0000;
    MemReq    = 1'b0;
    Halted    = 1'b0;
    Fault     = 1'b0;
    IllegalOp = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          MemReq = 1'b1;
          LoadIR = MemReady;
        end
        S_EXECUTE: begin
          case (Opcode)
            OP_ADD, OP_SUB, OP_NOR, OP_SHFL, OP_SHFR: begin
              LoadAcc = 1'b1;
              SelALU  = Opcode;
              IncPC   = 1'b1;
            end
            OP_R2A: begin
              LoadAcc = 1'b1;
              SelAcc  = 2'b01;
              IncPC   = 1'b1;
            end
            OP_I2A: begin
              LoadAcc = 1'b1;
              SelAcc  = 2'b10;
              IncPC   = 1'b1;
            end
            OP_A2R: begin
              LoadReg = 1'b1;
              IncPC   = 1'b1;
            end
            OP_JZR, OP_JZI: begin
              LoadPC = Z;
              SelPC  = Z & (Opcode == OP_JZI);
              IncPC  = ~Z;
            end
            OP_JNZR, OP_JNZI: begin
              LoadPC = ~Z;
              SelPC  = ~Z & (Opcode == OP_JNZI);
              IncPC  = Z;
            end
            OP_JCI: begin
              LoadPC = C;
              SelPC  = C;
              IncPC  = ~C;
            end
            OP_ILL: begin
              IncPC     = 1'b1;
              IllegalOp = 1'b1;
            end
            OP_HALT: ;
            default: IncPC = 1'b1;
          endcase
        end
        S_HALT: begin
          Halted = 1'b1;
          IncPC  = Resume;
        end
        default: Fault = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: expected strobe vectors and counts are queued
// as stimulus is applied and popped when the outputs are sampled on the falling edge.
module tb_multicycle_controller;

  localparam logic [15:0] B_MREQ    = 16'h8000;
  localparam logic [15:0] B_LIR     = 16'h4000;
  localparam logic [15:0] B_INC     = 16'h2000;
  localparam logic [15:0] B_LPC     = 16'h1000;
  localparam logic [15:0] B_SPC     = 16'h0800;
  localparam logic [15:0] B_LREG    = 16'h0400;
  localparam logic [15:0] B_LACC    = 16'h0200;
  localparam logic [15:0] B_ACC_IMM = 16'h0100;
  localparam logic [15:0] B_ACC_REG = 16'h0080;
  localparam logic [15:0] B_HALTED  = 16'h0004;
  localparam logic [15:0] B_FAULT   = 16'h0002;
  localparam logic [15:0] B_ILL     = 16'h0001;

  logic       Clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] Opcode = 4'h0;
  logic       Z = 1'b0, C = 1'b0, MemReady = 1'b0, Resume = 1'b0;

  logic        LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc, MemReq, Halted, Fault, IllegalOp;
  logic [1:0]  SelAcc;
  logic [3:0]  SelALU;
  logic [15:0] InstrCount;

  logic        LoadIR2, IncPC2, SelPC2, LoadPC2, LoadReg2, LoadAcc2, MemReq2, Halted2, Fault2, IllegalOp2;
  logic [1:0]  SelAcc2;
  logic [3:0]  SelALU2;
  logic [2:0]  InstrCount2;

  logic [15:0] obs;
  assign obs = {MemReq, LoadIR, IncPC, LoadPC, SelPC, LoadReg, LoadAcc,
                SelAcc, SelALU, Halted, Fault, IllegalOp};

  multicycle_controller #(.TIMEOUT(15), .CNT_W(16)) dut (
    .Clk(Clk), .reset(reset), .Opcode(Opcode), .Z(Z), .C(C), .MemReady(MemReady), .Resume(Resume),
    .LoadIR(LoadIR), .IncPC(IncPC), .SelPC(SelPC), .LoadPC(LoadPC), .LoadReg(LoadReg),
    .LoadAcc(LoadAcc), .SelAcc(SelAcc), .SelALU(SelALU), .MemReq(MemReq), .Halted(Halted),
    .Fault(Fault), .IllegalOp(IllegalOp), .InstrCount(InstrCount)
  );

  multicycle_controller #(.TIMEOUT(15), .CNT_W(3)) dut_sat (
    .Clk(Clk), .reset(reset), .Opcode(Opcode), .Z(Z), .C(C), .MemReady(MemReady), .Resume(Resume),
    .LoadIR(LoadIR2), .IncPC(IncPC2), .SelPC(SelPC2), .LoadPC(LoadPC2), .LoadReg(LoadReg2),
    .LoadAcc(LoadAcc2), .SelAcc(SelAcc2), .SelALU(SelALU2), .MemReq(MemReq2), .Halted(Halted2),
    .Fault(Fault2), .IllegalOp(IllegalOp2), .InstrCount(InstrCount2)
  );

  always #5 Clk = ~Clk;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] exp_q[$];
  logic [15:0] cnt_q[$];

  task automatic do_reset();
    reset = 1'b1;
    Opcode = 4'h0; Z = 1'b0; C = 1'b0; MemReady = 1'b0; Resume = 1'b0;
    @(posedge Clk);
    @(posedge Clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] ev, ec;
    #1 reset = 1'b1;
    MemReady = 1'b1; Opcode = 4'h1; Resume = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(16'h0000); cnt_q.push_back(16'd0);
      @(negedge Clk);
      ev = exp_q.pop_front(); ec = cnt_q.pop_front(); n_checks++;
      if (obs !== ev || InstrCount !== ec) begin
        n_fail++;
        $display("FAIL reset_hold %0d: out=%h cnt=%0d required out=%h cnt=%0d", i, obs, InstrCount, ev, ec);
      end
    end
    @(posedge Clk);
    #1 reset = 1'b0; MemReady = 1'b0;
    exp_q.push_back(B_MREQ); cnt_q.push_back(16'd0);
    @(negedge Clk);
    ev = exp_q.pop_front(); ec = cnt_q.pop_front(); n_checks++;
    if (obs !== ev || InstrCount !== ec) begin
      n_fail++;
      $display("FAIL reset_release: out=%h cnt=%0d required out=%h cnt=%0d", obs, InstrCount, ev, ec);
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_alu_stream();
    logic [15:0] ev, ec;
    do_reset();
    MemReady = 1'b1; Opcode = 4'b0001;
    for (int i = 0; i <= 10; i++) begin
      exp_q.push_back((i % 2 == 0) ? (B_MREQ | B_LIR) : (B_LACC | B_INC | 16'h0008));
      cnt_q.push_back(16'(i / 2));
      @(negedge Clk);
      ev = exp_q.pop_front(); ec = cnt_q.pop_front(); n_checks++;
      if (obs !== ev || InstrCount !== ec) begin
        n_fail++;
        $display("FAIL alu_stream %0d: out=%h cnt=%0d required out=%h cnt=%0d", i, obs, InstrCount, ev, ec);
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_opcodes();
    logic [15:0] ev, ec;
    logic [21:0] tbl [17];
    int          ecnt;
    tbl = '{
      {4'h7, 1'b1, 1'b0, B_LPC | B_SPC},
      {4'h7, 1'b0, 1'b0, B_INC},
      {4'h8, 1'b1, 1'b0, B_INC},
      {4'h9, 1'b0, 1'b1, B_LPC | B_SPC},
      {4'h9, 1'b0, 1'b0, B_INC},
      {4'h6, 1'b1, 1'b0, B_LPC},
      {4'hA, 1'b0, 1'b0, B_LPC | B_SPC},
      {4'hA, 1'b1, 1'b0, B_INC},
      {4'h4, 1'b0, 1'b0, B_LACC | B_INC | B_ACC_REG},
      {4'hD, 1'b0, 1'b0, B_LACC | B_INC | B_ACC_IMM},
      {4'h5, 1'b0, 1'b0, B_LREG | B_INC},
      {4'h0, 1'b1, 1'b1, B_INC},
      {4'h3, 1'b0, 1'b0, B_LACC | B_INC | 16'h0018},
      {4'hC, 1'b0, 1'b0, B_LACC | B_INC | 16'h0060},
      {4'hE, 1'b0, 1'b0, B_INC | B_ILL},
      {4'hB, 1'b0, 1'b0, B_LACC | B_INC | 16'h0058},
      {4'h2, 1'b1, 1'b1, B_LACC | B_INC | 16'h0010}
    };
    do_reset();
    ecnt = 0;
    MemReady = 1'b1;
    for (int i = 0; i < 17; i++) begin
      Opcode = 4'hF; Z = 1'b1; C = 1'b1;
      exp_q.push_back(B_MREQ | B_LIR); cnt_q.push_back(16'(ecnt));
      @(negedge Clk);
      ev = exp_q.pop_front(); ec = cnt_q.pop_front(); n_checks++;
      if (obs !== ev || InstrCount !== ec) begin
        n_fail++;
        $display("FAIL op_fetch %0d: out=%h cnt=%0d required out=%h cnt=%0d", i, obs, InstrCount, ev, ec);
      end
      @(posedge Clk); #1;
      Opcode = tbl[i][21:18]; Z = tbl[i][17]; C = tbl[i][16];
      exp_q.push_back(tbl[i][15:0]); cnt_q.push_back(16'(ecnt));
      @(negedge Clk);
      ev = exp_q.pop_front(); ec = cnt_q.pop_front(); n_checks++;
      if (obs !== ev || InstrCount !== ec) begin
        n_fail++;
        $display("FAIL op_exec %0d op=%h: out=%h cnt=%0d required out=%h cnt=%0d", i, Opcode, obs, InstrCount, ev, ec);
      end
      @(posedge Clk); #1;
      ecnt++;
    end
  endtask

  task automatic test_timeout();
    logic [15:0] ev, ec;
    do_reset();
    Opcode = 4'h0;
    for (int i = 1; i <= 31; i++) begin
      MemReady = (i == 15);
      if (i <= 15)      exp_q.push_back((i == 15) ? (B_MREQ | B_LIR) : B_MREQ);
      else if (i == 16) exp_q.push_back(B_INC);
      else              exp_q.push_back(B_MREQ);
      cnt_q.push_back((i <= 16) ? 16'd0 : 16'd1);
      @(negedge Clk);
      ev = exp_q.pop_front(); ec = cnt_q.pop_front(); n_checks++;
      if (obs !== ev || InstrCount !== ec) begin
        n_fail++;
        $display("FAIL timeout %0d: out=%h cnt=%0d required out=%h cnt=%0d", i, obs, InstrCount, ev, ec);
      end
      @(posedge Clk); #1;
    end
    MemReady = 1'b1; Resume = 1'b1; Opcode = 4'h1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(B_FAULT); cnt_q.push_back(16'd1);
      @(negedge Clk);
      ev = exp_q.pop_front(); ec = cnt_q.pop_front(); n_checks++;
      if (obs !== ev || InstrCount !== ec) begin
        n_fail++;
        $display("FAIL fault_hold %0d: out=%h cnt=%0d required out=%h cnt=%0d", i, obs, InstrCount, ev, ec);
      end
      @(posedge Clk); #1;
    end
    reset = 1'b1;
    exp_q.push_back(16'h0000); cnt_q.push_back(16'd0);
    #1;
    ev = exp_q.pop_front(); ec = cnt_q.pop_front(); n_checks++;
    if (obs !== ev || InstrCount !== ec) begin
      n_fail++;
      $display("FAIL fault_reset: out=%h cnt=%0d required out=%h cnt=%0d", obs, InstrCount, ev, ec);
    end
    @(posedge Clk);
    #1 reset = 1'b0; MemReady = 1'b0; Resume = 1'b0;
    exp_q.push_back(B_MREQ); cnt_q.push_back(16'd0);
    @(negedge Clk);
    ev = exp_q.pop_front(); ec = cnt_q.pop_front(); n_checks++;
    if (obs !== ev || InstrCount !== ec) begin
      n_fail++;
      $display("FAIL fault_recover: out=%h cnt=%0d required out=%h cnt=%0d", obs, InstrCount, ev, ec);
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_halt();
    logic [15:0] ev, ec;
    logic [15:0] seq_e [11];
    logic [15:0] seq_c [11];
    logic [3:0]  seq_op [11];
    logic        seq_res [11];
    seq_e   = '{B_MREQ | B_LIR, 16'h0000, B_HALTED, B_HALTED, B_HALTED, B_HALTED, B_HALTED,
                B_HALTED | B_INC, B_MREQ | B_LIR, 16'h0000, B_HALTED};
    seq_c   = '{16'd0, 16'd0, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd2};
    seq_op  = '{4'hF, 4'hF, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 4'h1};
    seq_res = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    do_reset();
    MemReady = 1'b1; Z = 1'b1; C = 1'b1;
    for (int i = 0; i < 11; i++) begin
      Opcode = seq_op[i]; Resume = seq_res[i];
      exp_q.push_back(seq_e[i]); cnt_q.push_back(seq_c[i]);
      @(negedge Clk);
      ev = exp_q.pop_front(); ec = cnt_q.pop_front(); n_checks++;
      if (obs !== ev || InstrCount !== ec) begin
        n_fail++;
        $display("FAIL halt %0d: out=%h cnt=%0d required out=%h cnt=%0d", i, obs, InstrCount, ev, ec);
      end
      @(posedge Clk); #1;
    end
    #2 reset = 1'b1;
    exp_q.push_back(16'h0000); cnt_q.push_back(16'd0);
    #1;
    ev = exp_q.pop_front(); ec = cnt_q.pop_front(); n_checks++;
    if (obs !== ev || InstrCount !== ec) begin
      n_fail++;
      $display("FAIL halt_reset: out=%h cnt=%0d required out=%h cnt=%0d", obs, InstrCount, ev, ec);
    end
    @(posedge Clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_saturate();
    logic [15:0] ec;
    do_reset();
    MemReady = 1'b1; Opcode = 4'h1;
    for (int i = 0; i < 24; i++) begin
      cnt_q.push_back(16'((i / 2 > 7) ? 7 : i / 2));
      @(negedge Clk);
      ec = cnt_q.pop_front(); n_checks++;
      if ({13'd0, InstrCount2} !== ec) begin
        n_fail++;
        $display("FAIL saturate %0d: cnt=%0d required cnt=%0d", i, InstrCount2, ec);
      end
      @(posedge Clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_alu_stream();
    test_opcodes();
    test_timeout();
    test_halt();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
